// File: rtl/mem_port_arbiter.sv
// Two-master arbiter/sequencer in front of a single-port asynchronous memory.
// Master 0 is the CPU, master 1 a loader/DMA/debug port. One request is served
// at a time: the winner's address, write data and direction are latched at the
// grant edge. mem_read or mem_write is then driven from registered state for
// long enough to cover the memory access time, and the master gets a
// single-cycle ack. No combinational path exists from any mN_* input to any
// output.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3,   // cycles mem_read is held; 1..15
  parameter bit          FIXED_PRIO  = 1'b0 // 1: master 0 always wins ties
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] READ_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        we_q, we_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel;

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      we_q         <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      we_q         <= we_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Arbitration, request latching, wait counting and read-data capture.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    we_d         = we_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    sel          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
          sel = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end else begin
          sel = m1_req;
        end
        if (m0_req || m1_req) begin
          grant_d = sel;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          we_d    = sel ? m1_we    : m0_we;
          cnt_d   = (sel ? m1_we : m0_we) ? 4'd0 : READ_CNT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (grant_q) begin
              m1_rdata_d = mem_read_data;
            end else begin
              m0_rdata_d = mem_read_data;
            end
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_read       = (state_q == ACCESS) && !we_q;
  assign mem_write      = (state_q == ACCESS) &&  we_q;
  assign m0_ack         = (state_q == DONE) && !grant_q;
  assign m1_ack         = (state_q == DONE) &&  grant_q;
  assign m0_rdata       = m0_rdata_q;
  assign m1_rdata       = m1_rdata_q;
  assign grant          = grant_q;
  assign busy           = (state_q != IDLE);

endmodule
